// File: rtl/rand_pkg.sv
// Shared types and helpers for the entropy sampler: FSM state encoding and the
// von Neumann pair decoder used by the extractor.
package rand_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } sampler_state_e;

  // Result of decoding one (first, second) raw pair.
  typedef struct packed {
    logic emit;   // pair is 10 or 01
    logic bit_v;  // value emitted when emit=1
  } vn_out_t;

  // 10 -> emit 1, 01 -> emit 0, 00/11 -> nothing.
  function automatic vn_out_t vn_decode(input logic first, input logic second);
    vn_out_t r;
    r.emit  = first ^ second;
    r.bit_v = first;
    return r;
  endfunction

endpackage

// File: rtl/entropy_sampler_if.sv
// Output word stream of the entropy sampler: data plus valid/ready handshake.
interface entropy_sampler_if #(
  parameter int OUT_WIDTH = 32
);
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/entropy_sync.sv
// Per-bit flip-flop synchroniser chains bringing the free-running ring
// oscillator bits into the sampling clock domain.
module entropy_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [SYNC_STAGES-1:0] chain_q;

    // Shift the asynchronous bit through SYNC_STAGES flops.
    always_ff @(posedge clk) begin
      if (reset) chain_q <= '0;
      else       chain_q <= {chain_q[SYNC_STAGES-2:0], async_i[b]};
    end

    assign sync_o[b] = chain_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/entropy_sampler.sv
// Entropy sampler: synchronises ring oscillator state, XOR-folds it to one raw
// bit per cycle, whitens with a von Neumann extractor, packs bits into words
// on a valid/ready port and guards the source with a repetition-count test.
module entropy_sampler
  import rand_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int OUT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int REP_LIMIT   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     state,
  input  logic                 enable,
  entropy_sampler_if.master    out,
  output logic                 health_fail
);

  localparam int CW = $clog2(OUT_WIDTH + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [WIDTH-1:0]     sync_w;
  sampler_state_e       fsm_q, fsm_d;
  logic                 raw_q, raw_d;
  logic                 prev_q, prev_d;
  logic                 first_q, first_d;
  logic                 phase_q, phase_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [RW-1:0]        rep_q, rep_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;

  logic                 trip, active, emit, full, load, xfer;
  logic [OUT_WIDTH-1:0] acc_shift;
  vn_out_t              vn;

  entropy_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (state),
    .sync_o  (sync_w)
  );

  assign trip        = (rep_q == RW'(REP_LIMIT));
  assign health_fail = (fsm_q == FAIL);
  assign active      = enable && !health_fail;
  assign vn          = vn_decode(first_q, raw_q);
  assign emit        = active && phase_q && vn.emit;
  assign full        = (cnt_q == CW'(OUT_WIDTH));
  assign xfer        = out_valid_q && out.out_ready;
  // A full accumulator moves out when the output slot is empty or draining now.
  assign load        = full && (!out_valid_q || out.out_ready);
  assign acc_shift   = {acc_q[OUT_WIDTH-2:0], vn.bit_v};

  assign out.out_data  = out_data_q;
  assign out.out_valid = out_valid_q && !health_fail;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  // FSM next state: a health trip wins over enable; FAIL only leaves on reset.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (trip) fsm_d = FAIL; else if (enable)  fsm_d = RUN;
      RUN:     if (trip) fsm_d = FAIL; else if (!enable) fsm_d = IDLE;
      FAIL:    fsm_d = FAIL;
      default: fsm_d = IDLE;
    endcase
  end

  // Datapath next state: raw fold, health counter, extractor and packer.
  always_comb begin
    raw_d       = ^sync_w;
    prev_d      = raw_q;
    first_d     = first_q;
    phase_d     = phase_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    rep_d       = rep_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    // Repetition counter keeps running while output is stalled.
    if (enable) begin
      if (raw_q != prev_q)  rep_d = RW'(1);
      else if (!trip)       rep_d = rep_q + RW'(1);
    end

    // Extractor phase: frozen after a failure, parked at 0 while paused.
    if (!health_fail) begin
      if (enable) phase_d = ~phase_q;
      else        phase_d = 1'b0;
    end
    if (active && !phase_q) first_d = raw_q;

    if (health_fail) begin
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else if (load) begin
      out_data_d  = acc_q;
      out_valid_d = 1'b1;
      // A bit emitted on the load cycle starts the next word.
      if (emit) begin
        acc_d = acc_shift;
        cnt_d = CW'(1);
      end else begin
        cnt_d = '0;
      end
    end else begin
      if (xfer) out_valid_d = 1'b0;
      // With a full accumulator and a stalled output, new bits are dropped.
      if (emit && !full) begin
        acc_d = acc_shift;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q       <= 1'b0;
      prev_q      <= 1'b0;
      first_q     <= 1'b0;
      phase_q     <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      rep_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      raw_q       <= raw_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
